// File: rtl/door_pkg.sv
// Shared types and constants for the door-lock controller: setup packet,
// PIN packet, six-digit BCD display packet, key codes, tick constants and
// the state encoding of the configuration menu.
package door_pkg;

  localparam logic [3:0] KEY_CONFIRM = 4'hF;  // '#'
  localparam logic [3:0] KEY_CANCEL  = 4'hE;  // '*'
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  // Tick counts at the 1 kHz system clock
  localparam logic [15:0] UM_SEG       = 16'd1000;
  localparam logic [15:0] CINCO_SEG    = 16'd5000;
  localparam logic [15:0] TRINTA_SEG   = 16'd30000;
  localparam logic [15:0] SESSENTA_SEG = 16'd60000;

  // digit1 is the first digit typed
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef struct packed {
    logic        bip_status;
    logic [15:0] bip_time;
    logic [15:0] tranca_aut_time;
    pinPac_t     master_pin;
    pinPac_t     pin1;
    pinPac_t     pin2;
    pinPac_t     pin3;
    pinPac_t     pin4;
  } setupPac_t;

  typedef struct packed {
    logic [3:0] bcd5;
    logic [3:0] bcd4;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } bcdPac_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_BIP_EN     = 4'd2,
    ST_BIP_TIME   = 4'd3,
    ST_TRAVA_TIME = 4'd4,
    ST_PIN_SEL    = 4'd5,
    ST_PIN_EDIT   = 4'd6,
    ST_SAVE       = 4'd7,
    ST_ABORT      = 4'd8,
    ST_DONE       = 4'd9
  } setup_state_t;

endpackage

// File: rtl/setup_num_entry.sv
// Digit entry buffer for the configuration menu. Shifts decimal digits in
// (newest digit in position 0), keeps a digit count and the binary value,
// and refuses digits once the count reaches limit_i. Positions not yet typed
// read as BCD_BLANK. clr_i has priority over push_i.
module setup_num_entry
  import door_pkg::*;
#(
  parameter  int N_MAX = 4,
  localparam int CW    = $clog2(N_MAX + 1),
  localparam int VW    = $clog2(10 ** N_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [3:0]              digit_i,
  input  logic [CW-1:0]           limit_i,
  output logic [CW-1:0]           count_o,
  output logic [VW-1:0]           value_o,
  output logic [N_MAX-1:0][3:0]   bcd_o
);

  logic [CW-1:0]         count_q;
  logic [VW-1:0]         value_q;
  logic [N_MAX-1:0][3:0] dig_q;

  // Accumulate digits until the per-field limit; clear wipes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      value_q <= '0;
      dig_q   <= {N_MAX{BCD_BLANK}};
    end else if (clr_i) begin
      count_q <= '0;
      value_q <= '0;
      dig_q   <= {N_MAX{BCD_BLANK}};
    end else if (push_i && (count_q < limit_i)) begin
      count_q <= count_q + CW'(1);
      value_q <= value_q * VW'(10) + VW'(digit_i);
      dig_q   <= {dig_q[N_MAX-2:0], digit_i};
    end
  end

  assign count_o = count_q;
  assign value_o = value_q;
  assign bcd_o   = dig_q;

endmodule

// File: rtl/setup_config.sv
// Configuration-menu responder for the door-lock controller. While
// setup_on is held it owns keypad and display, edits a working copy of the
// setup packet and returns it (or the untouched copy on cancel) with a
// one-cycle setup_end pulse. Master PIN passes through untouched.
// Optional build macro SETUP_TIMEOUT_EN adds an inactivity abort after
// TIMEOUT_TCK ticks without a key; without it the menu waits forever.
// Key handshake: key_valid is a level; one key is taken on each rising
// edge of key_valid, with key_code sampled in that same cycle.
module setup_config
  import door_pkg::*;
#(
  parameter int unsigned MIN_SEC    = 5,
  parameter int unsigned MAX_SEC    = 60,
  parameter int unsigned MS_PER_SEC = 1000
`ifdef SETUP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_TCK = 30000
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         setup_on,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  setupPac_t    data_setup_old,
  output setupPac_t    data_setup_new,
  output logic         setup_end,
  output bcdPac_t      bcd_out,
  output logic         bcd_enable,
  output setup_state_t dbg_state_o
);

  localparam int ENT_N  = 4;
  localparam int ENT_VW = $clog2(10 ** ENT_N);

  setup_state_t state_q, state_prev_q;
  setupPac_t    work_q, old_q, new_q;
  logic         end_q;
  logic [2:0]   sel_q;
  logic         setup_on_q, key_q;

  logic                  key_ev, editing, timeout, ent_push, ent_clr;
  logic [2:0]            ent_limit, ent_cnt;
  logic [ENT_VW-1:0]     ent_val;
  logic [ENT_N-1:0][3:0] ent_bcd;
  int unsigned           sec_c;
  logic [15:0]           ticks_c;
  pinPac_t               pin_cur_c, pin_upd_c;

  // Edge history for setup_on, key_valid and the state (buffer clear on change)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_on_q   <= 1'b0;
      key_q        <= 1'b0;
      state_prev_q <= ST_IDLE;
    end else begin
      setup_on_q   <= setup_on;
      key_q        <= key_valid;
      state_prev_q <= state_q;
    end
  end

  assign key_ev    = key_valid && !key_q;
  assign editing   = state_q inside {ST_BIP_EN, ST_BIP_TIME, ST_TRAVA_TIME, ST_PIN_SEL, ST_PIN_EDIT};
  assign ent_clr   = (state_q != state_prev_q);
  assign ent_push  = key_ev && (key_code <= 4'd9) &&
                     (state_q inside {ST_BIP_TIME, ST_TRAVA_TIME, ST_PIN_EDIT});
  assign ent_limit = (state_q == ST_PIN_EDIT) ? 3'd4 : 3'd2;

  setup_num_entry #(.N_MAX(ENT_N)) u_entry (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ent_clr),
    .push_i  (ent_push),
    .digit_i (key_code),
    .limit_i (ent_limit),
    .count_o (ent_cnt),
    .value_o (ent_val),
    .bcd_o   (ent_bcd)
  );

`ifdef SETUP_TIMEOUT_EN
  logic [15:0] idle_cnt_q;

  // Inactivity counter: restarts on each key and on LOAD, runs while editing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (state_q == ST_LOAD || key_ev) begin
      idle_cnt_q <= '0;
    end else if (editing && idle_cnt_q != 16'(TIMEOUT_TCK)) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign timeout = editing && (idle_cnt_q == 16'(TIMEOUT_TCK));
`else
  assign timeout = 1'b0;
`endif

  // Entered seconds clamped to [MIN_SEC, MAX_SEC], converted to ticks; PIN update
  always_comb begin
    sec_c = 32'(ent_val);
    if (sec_c < MIN_SEC)      sec_c = MIN_SEC;
    else if (sec_c > MAX_SEC) sec_c = MAX_SEC;
    ticks_c = 16'(sec_c * MS_PER_SEC);

    case (sel_q)
      3'd2:    pin_cur_c = work_q.pin2;
      3'd3:    pin_cur_c = work_q.pin3;
      3'd4:    pin_cur_c = work_q.pin4;
      default: pin_cur_c = work_q.pin1;
    endcase
    pin_upd_c = pin_cur_c;
    if (ent_cnt == 3'd4)                         pin_upd_c = pinPac_t'({1'b1, ent_bcd});
    else if (ent_cnt == 3'd0 && sel_q != 3'd1)   pin_upd_c.status = 1'b0;
  end

  // Menu FSM; setup_on dropping wins, then cancel/timeout, then per-state keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      old_q   <= '0;
      new_q   <= '0;
      end_q   <= 1'b0;
      sel_q   <= 3'd1;
    end else begin
      end_q <= 1'b0;
      if (state_q != ST_IDLE && !setup_on) begin
        state_q <= ST_IDLE;
      end else if (editing && (timeout || (key_ev && key_code == KEY_CANCEL))) begin
        state_q <= ST_ABORT;
      end else begin
        unique case (state_q)
          ST_IDLE: if (setup_on && !setup_on_q) state_q <= ST_LOAD;
          ST_LOAD: begin
            work_q  <= data_setup_old;
            old_q   <= data_setup_old;
            sel_q   <= 3'd1;
            state_q <= ST_BIP_EN;
          end
          ST_BIP_EN: if (key_ev) begin
            if (key_code == KEY_CONFIRM)                  state_q <= ST_BIP_TIME;
            else if (key_code == 4'd0 || key_code == 4'd1) work_q.bip_status <= key_code[0];
          end
          ST_BIP_TIME: if (key_ev && key_code == KEY_CONFIRM) begin
            if (ent_cnt != 3'd0) work_q.bip_time <= ticks_c;
            state_q <= ST_TRAVA_TIME;
          end
          ST_TRAVA_TIME: if (key_ev && key_code == KEY_CONFIRM) begin
            if (ent_cnt != 3'd0) work_q.tranca_aut_time <= ticks_c;
            state_q <= ST_PIN_SEL;
          end
          ST_PIN_SEL: if (key_ev) begin
            if (key_code == KEY_CONFIRM) begin
              state_q <= ST_SAVE;
            end else if (key_code inside {[4'd1:4'd4]}) begin
              sel_q   <= key_code[2:0];
              state_q <= ST_PIN_EDIT;
            end
          end
          ST_PIN_EDIT: if (key_ev && key_code == KEY_CONFIRM &&
                           (ent_cnt == 3'd0 || ent_cnt == 3'd4)) begin
            case (sel_q)
              3'd2:    work_q.pin2 <= pin_upd_c;
              3'd3:    work_q.pin3 <= pin_upd_c;
              3'd4:    work_q.pin4 <= pin_upd_c;
              default: work_q.pin1 <= pin_upd_c;
            endcase
            state_q <= ST_PIN_SEL;
          end
          ST_SAVE: begin
            new_q   <= work_q;
            end_q   <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_ABORT: begin
            new_q   <= old_q;
            end_q   <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Display decode from registered state; untouched digits stay blank
  always_comb begin
    bcd_out = {6{BCD_BLANK}};
    unique case (state_q)
      ST_BIP_EN: begin
        bcd_out.bcd5 = 4'd1;
        bcd_out.bcd0 = {3'b000, work_q.bip_status};
      end
      ST_BIP_TIME, ST_TRAVA_TIME: begin
        bcd_out.bcd5 = (state_q == ST_BIP_TIME) ? 4'd2 : 4'd3;
        bcd_out.bcd1 = ent_bcd[1];
        bcd_out.bcd0 = ent_bcd[0];
      end
      ST_PIN_SEL: begin
        bcd_out.bcd5 = 4'd4;
        bcd_out.bcd0 = {1'b0, sel_q};
      end
      ST_PIN_EDIT: begin
        bcd_out.bcd5 = 4'd4;
        bcd_out.bcd4 = {1'b0, sel_q};
        bcd_out.bcd3 = ent_bcd[3];
        bcd_out.bcd2 = ent_bcd[2];
        bcd_out.bcd1 = ent_bcd[1];
        bcd_out.bcd0 = ent_bcd[0];
      end
      default: ;
    endcase
  end

  assign data_setup_new = new_q;
  assign setup_end      = end_q;
  assign bcd_enable     = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_setup_config.sv
// Bench for setup_config: drives menu sessions through the keypad and
// checks the returned packet, the setup_end pulse and the display.
module tb_setup_config;
  import door_pkg::*;

  localparam int SW = $bits(setupPac_t);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         setup_on = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  setupPac_t    data_setup_old = '0;
  setupPac_t    data_setup_new;
  logic         setup_end;
  bcdPac_t      bcd_out;
  logic         bcd_enable;
  setup_state_t dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  int n_end = 0;
  int n_pushed = 0;
  logic end_prev = 1'b0;
  logic [SW-1:0] exp_q[$];
  setupPac_t last_new = '0;
  setupPac_t old0, e;

  setup_config dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .data_setup_old (data_setup_old),
    .data_setup_new (data_setup_new),
    .setup_end      (setup_end),
    .bcd_out        (bcd_out),
    .bcd_enable     (bcd_enable),
    .dbg_state_o    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic press(input logic [3:0] c, input int hold = 2);
    @(negedge clk);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start(input setupPac_t old);
    @(negedge clk);
    data_setup_old = old;
    setup_on       = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic stop();
    @(negedge clk);
    setup_on = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_end(input setupPac_t p);
    exp_q.push_back(p);
    n_pushed++;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (n_end < n_pushed && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("end_seen", 128'(n_end), 128'(n_pushed));
    stop();
  endtask

  // ---- scoreboard ----
  always @(negedge clk) begin
    if (!rst && setup_end) begin
      chk("end_pulse", 128'(end_prev), 128'(0));
      if (exp_q.size() == 0) begin
        chk("unexpected_end", 128'(1), 128'(0));
      end else begin
        last_new = setupPac_t'(exp_q.pop_front());
        chk("data_new", 128'(data_setup_new), 128'(last_new));
      end
      n_end++;
    end
    end_prev = setup_end;
  end

  initial begin
    old0 = '0;
    old0.bip_status      = 1'b1;
    old0.bip_time        = 16'd10000;
    old0.tranca_aut_time = 16'd15000;
    old0.master_pin      = pinPac_t'({1'b1, 16'h1234});
    old0.pin1            = pinPac_t'({1'b1, 16'h5555});
    old0.pin2            = pinPac_t'({1'b0, 16'h0000});
    old0.pin3            = pinPac_t'({1'b1, 16'h9876});
    old0.pin4            = pinPac_t'({1'b1, 16'h4444});

    // reset
    repeat (3) @(negedge clk);
    chk("rst_end", 128'(setup_end), 128'(0));
    chk("rst_en", 128'(bcd_enable), 128'(0));
    chk("rst_bcd", 128'(bcd_out), 128'(24'hFFFFFF));
    chk("rst_new", 128'(data_setup_new), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: confirm straight through
    start(old0);
    chk("t1_en", 128'(bcd_enable), 128'(1));
    chk("t1_bcd", 128'(bcd_out), 128'(24'h1FFFF1));
    press(KEY_CONFIRM); press(KEY_CONFIRM); press(KEY_CONFIRM);
    chk("t1_pinsel_bcd", 128'(bcd_out), 128'(24'h4FFFF1));
    expect_end(old0);
    press(KEY_CONFIRM);
    wait_end(50);
    chk("t1_off_en", 128'(bcd_enable), 128'(0));

    // 2: bip off, bip time 20 s, third digit ignored
    start(old0);
    press(4'd0);
    chk("t2_status_bcd", 128'(bcd_out), 128'(24'h1FFFF0));
    press(KEY_CONFIRM);
    chk("t2_bt_empty", 128'(bcd_out), 128'(24'h2FFFFF));
    press(4'd2);
    chk("t2_bt_2", 128'(bcd_out), 128'(24'h2FFFF2));
    press(4'd0);
    press(4'd5);
    chk("t2_bt_20", 128'(bcd_out), 128'(24'h2FFF20));
    press(KEY_CONFIRM);
    chk("t2_trava_bcd", 128'(bcd_out), 128'(24'h3FFFFF));
    press(KEY_CONFIRM);
    e = old0; e.bip_status = 1'b0; e.bip_time = 16'd20000;
    expect_end(e);
    press(KEY_CONFIRM);
    wait_end(50);

    // 3: clamp low (3 s) and clamp high (99 s); A-D ignored
    start(old0);
    press(KEY_CONFIRM);
    press(4'hA);
    chk("t3_keyA", 128'(bcd_out), 128'(24'h2FFFFF));
    press(4'd3); press(KEY_CONFIRM);
    press(4'd9); press(4'd9); press(KEY_CONFIRM);
    e = old0; e.bip_time = CINCO_SEG; e.tranca_aut_time = SESSENTA_SEG;
    expect_end(e);
    press(KEY_CONFIRM);
    wait_end(50);

    // 4: PIN editing
    start(old0);
    press(KEY_CONFIRM); press(KEY_CONFIRM); press(KEY_CONFIRM);
    press(4'd2);
    chk("t4_edit_empty", 128'(bcd_out), 128'(24'h42FFFF));
    press(4'd7); press(4'd3); press(4'd1); press(4'd9); press(4'd5);
    chk("t4_edit_full", 128'(bcd_out), 128'(24'h427319));
    press(KEY_CONFIRM);
    chk("t4_back_sel", 128'(bcd_out), 128'(24'h4FFFF2));
    press(4'd3); press(4'd4); press(4'd2); press(KEY_CONFIRM);
    chk("t4_partial_state", 128'(dbg_state), 128'(ST_PIN_EDIT));
    chk("t4_partial_bcd", 128'(bcd_out), 128'(24'h43FF42));
    press(4'd0); press(4'd1); press(KEY_CONFIRM);
    press(4'd1); press(KEY_CONFIRM);
    press(4'd4); press(KEY_CONFIRM);
    chk("t4_sel_state", 128'(dbg_state), 128'(ST_PIN_SEL));
    e = old0;
    e.pin2 = pinPac_t'({1'b1, 16'h7319});
    e.pin3 = pinPac_t'({1'b1, 16'h4201});
    e.pin4 = pinPac_t'({1'b0, 16'h4444});
    expect_end(e);
    press(KEY_CONFIRM);
    wait_end(50);

    // 5: edit then cancel in PIN_SEL returns the LOAD copy
    start(old0);
    press(KEY_CONFIRM); press(4'd3); press(4'd0); press(KEY_CONFIRM);
    press(KEY_CONFIRM);
    expect_end(old0);
    press(KEY_CANCEL);
    wait_end(50);

    // 6: setup_on dropped mid-session
    start(old0);
    press(4'd0);
    @(negedge clk);
    setup_on = 1'b0;
    @(negedge clk);
    chk("t6_state", 128'(dbg_state), 128'(ST_IDLE));
    chk("t6_en", 128'(bcd_enable), 128'(0));
    chk("t6_bcd", 128'(bcd_out), 128'(24'hFFFFFF));
    repeat (5) @(negedge clk);
    chk("t6_new_held", 128'(data_setup_new), 128'(last_new));

    // 7: long key holds give one event each; menu waits while idle
    start(old0);
    repeat (200) @(negedge clk);
    chk("t7_wait_state", 128'(dbg_state), 128'(ST_BIP_EN));
    press(KEY_CONFIRM, 10);
    chk("t7_hold_state", 128'(dbg_state), 128'(ST_BIP_TIME));
    press(4'd4, 10);
    chk("t7_hold_bcd", 128'(bcd_out), 128'(24'h2FFFF4));
    press(KEY_CONFIRM); press(KEY_CONFIRM);
    e = old0; e.bip_time = CINCO_SEG;
    expect_end(e);
    press(KEY_CONFIRM);
    wait_end(50);

`ifdef SETUP_TIMEOUT_EN
    // 8: inactivity abort
    start(old0);
    press(4'd0);
    expect_end(old0);
    wait_end(int'(TRINTA_SEG) + 100);
`endif

    // 9: reset mid-session
    start(e);
    press(4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_state", 128'(dbg_state), 128'(ST_IDLE));
    chk("t9_end", 128'(setup_end), 128'(0));
    chk("t9_en", 128'(bcd_enable), 128'(0));
    chk("t9_bcd", 128'(bcd_out), 128'(24'hFFFFFF));
    chk("t9_new", 128'(data_setup_new), 128'(0));
    setup_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_left", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
